// File: rtl/subleq_core.sv
// SUBLEQ execution controller: sequences operand fetch, operand loads and the
// mem[B] -= mem[A] write-back, branching to C when the result is <= 0.
module subleq_core #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [63:0]      mem_addr,
    output logic [63:0]      mem_wdata,
    output logic             mem_we,
    output logic             mem_re,
    input  logic [63:0]      mem_rdata,
    output logic [63:0]      pc,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam int DATA_W = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FA,
        S_FB,
        S_FC,
        S_LA,
        S_LB,
        S_EX,
        S_HALT
    } state_t;

    state_t                    state_q, state_d;
    logic [DATA_W-1:0]         pc_q, pc_d;
    logic [DATA_W-1:0]         a_q, a_d;
    logic [DATA_W-1:0]         b_q, b_d;
    logic [DATA_W-1:0]         c_q, c_d;
    logic [DATA_W-1:0]         va_q, va_d;
    logic [CNT_W-1:0]          retired_q, retired_d;
    logic                      halted_q, halted_d;

    logic signed [DATA_W-1:0]  res;
    logic                      leq;
    logic [DATA_W-1:0]         next_pc;

    function automatic logic is_leq(input logic signed [DATA_W-1:0] v);
        return v <= 0;
    endfunction

    // mem_rdata in EX carries mem[B] from the read issued in LB
    assign res     = $signed(mem_rdata) - $signed(va_q);
    assign leq     = is_leq(res);
    assign next_pc = leq ? c_q : pc_q + 64'd3;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            va_q      <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            va_q      <= va_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        va_d      = va_q;
        retired_d = retired_q;
        halted_d  = halted_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_FA;
            S_FA:   state_d = S_FB;
            S_FB: begin
                a_d     = mem_rdata;
                state_d = S_FC;
            end
            S_FC: begin
                b_d     = mem_rdata;
                state_d = S_LA;
            end
            S_LA: begin
                c_d     = mem_rdata;
                state_d = S_LB;
            end
            S_LB: begin
                va_d    = mem_rdata;
                state_d = S_EX;
            end
            S_EX: begin
                pc_d      = next_pc;
                retired_d = retired_q + CNT_W'(1);
                // a taken branch to a negative target is the halt idiom
                if (leq && c_q[DATA_W-1]) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    state_d  = run ? S_FA : S_IDLE;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_FA: begin
                mem_re   = 1'b1;
                mem_addr = pc_q;
            end
            S_FB: begin
                mem_re   = 1'b1;
                mem_addr = pc_q + 64'd1;
            end
            S_FC: begin
                mem_re   = 1'b1;
                mem_addr = pc_q + 64'd2;
            end
            S_LA: begin
                mem_re   = 1'b1;
                mem_addr = a_q;
            end
            S_LB: begin
                mem_re   = 1'b1;
                mem_addr = b_q;
            end
            S_EX: begin
                mem_we    = 1'b1;
                mem_addr  = b_q;
                mem_wdata = res;
            end
            default: ;
        endcase
        // strobes are gated so a write pending in EX is dropped under reset
        if (!rst) begin
            mem_re = 1'b0;
            mem_we = 1'b0;
        end
    end

    assign pc      = pc_q;
    assign halted  = halted_q;
    assign retired = retired_q;

endmodule
